controlador_corrimiento: RTL
============================

Name: controlador_corrimiento

Overview:
Multi-cycle shift/rotate sequencer for the ARMv4 datapath. It executes the barrel-shifter operations LSL, LSR, ASR, ROR and RRX with full ARM register-specified shift-amount and carry-out semantics. It processes STEP bit positions per cycle over a registered working value, trading latency for area against a full combinational shifter. It sits between decode/issue (request side) and the ALU operand-2 path (result side), with valid/ready handshakes on both sides.

Parameters:
N, 32, datapath width in bits
STEP, 4, maximum bit positions shifted per SHIFT cycle; legal values 1, 2, 4, 8

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
op  input  3  operation: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX; 5-7 pass-through
value  input  N  operand to shift
amount  input  8  shift amount (bottom byte of Rs)
carry_in  input  1  current C flag
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
result  output  N  shifted operand, registered
carry_out  output  1  shifter carry-out, registered
busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - req_ready=1, res_valid=0, busy=0, result=0, carry_out=0.
  - Reset in any state aborts the operation; no result is produced.
- FSM: IDLE -> SHIFT or DONE; SHIFT -> SHIFT or DONE; DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - Accept on req_valid && req_ready; latch op, value and carry_in.
  - Compute effective count c:
    - LSL/LSR: min(amount,33).
    - ASR: min(amount,32).
    - ROR: amount[4:0]; if that is 0 and amount!=0, c=32.
    - RRX: 1.
    - amount==0, or op 5-7: c=0.
  - Set carry register to carry_in. Go to SHIFT if c>0, else DONE.
- SHIFT:
  - Each cycle shifts k=min(STEP,remaining) positions and decrements remaining by k.
  - Carry register takes the last bit shifted out in that cycle.
  - Fill bits:
    - LSL/LSR: 0.
    - ASR: value[N-1] (sign bit).
    - ROR: bits shifted out.
    - RRX: carry_in.
  - Go to DONE when remaining reaches 0.
- Resulting ARM semantics (fall out of the clamping; the verifier checks them):
  - LSL by 32: result 0, C=value[0].
  - LSR by 32: result 0, C=value[31].
  - LSL/LSR by more than 32: result 0, C=0.
  - ASR by 32 or more: result all sign bits, C=sign.
  - ROR by a nonzero multiple of 32: result unchanged, C=value[31].
  - Amount 0: result=value, C=carry_in.
- DONE:
  - res_valid=1; result and carry_out are stable.
  - On res_ready, go to IDLE; res_valid drops the next cycle.
  - Backpressure has no timeout.
- Latency:
  - res_valid rises 1+ceil(c/STEP) cycles after the accept edge (1 cycle when c=0).
  - Throughput: one request per latency+1 cycles minimum.
  - req_ready=0 while busy; new requests are never accepted in DONE, even if res_ready=1.
- Outputs change only on clk edges; no combinational path from inputs to outputs.

Test Plan (N=32, STEP=4):
- LSL, value 0x000000F1, amount 4 -> result 0x00000F10, C=0, res_valid 2 cycles after accept.
- LSR 0x80000001 amount 32 -> result 0, C=1, latency 9; same value, amount 40 -> result 0, C=0, latency 10.
- ASR 0x80000000 amount 31 -> result 0xFFFFFFFF, C=0; amount 200 -> result 0xFFFFFFFF, C=1.
- ROR 0x000000F0 amount 4 -> result 0x0000000F, C=0; ROR 0x80000000 amount 32 -> result 0x80000000, C=1; any op with amount 0 and carry_in=1 -> result=value, C=1, latency 1.
- RRX 0x00000003 with carry_in=1 -> result 0x80000001, C=1, latency 2; op=6 -> pass-through, C=carry_in.
- Hold res_ready=0 for 5 cycles in DONE -> result/carry_out stable, req_ready=0, new req_valid ignored. Assert reset during SHIFT -> next cycle IDLE, res_valid=0, result=0, req_ready=1.

Source files
------------

// File: rtl/controlador_corrimiento_if.sv
// rtl/controlador_corrimiento_if.sv - request/result handshake bundle for the shift sequencer
interface controlador_corrimiento_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   op;
    logic [N-1:0] value;
    logic [7:0]   amount;
    logic         carry_in;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] result;
    logic         carry_out;
    logic         busy;

    modport master (
        output req_valid, op, value, amount, carry_in, res_ready,
        input  req_ready, res_valid, result, carry_out, busy
    );

    modport slave (
        input  req_valid, op, value, amount, carry_in, res_ready,
        output req_ready, res_valid, result, carry_out, busy
    );
endinterface

// File: rtl/controlador_corrimiento.sv
// rtl/controlador_corrimiento.sv - multi-cycle ARM LSL/LSR/ASR/ROR/RRX shift sequencer
module controlador_corrimiento #(
    parameter int N    = 32,
    parameter int STEP = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    controlador_corrimiento_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state, state_next;
    logic [2:0]   op_q;
    logic [N-1:0] work, work_next;
    logic         carry, carry_next;
    logic         fill_q;
    logic [5:0]   remaining, count_eff, k;

    // Clamping the count is what produces the ARM by-32 / over-32 carry results.
    always_comb begin
        count_eff = '0;
        if (bus.amount != 8'd0) begin
            case (bus.op)
                3'd0, 3'd1: count_eff = (bus.amount > 8'd33) ? 6'd33 : bus.amount[5:0];
                3'd2:       count_eff = (bus.amount > 8'd32) ? 6'd32 : bus.amount[5:0];
                3'd3:       count_eff = (bus.amount[4:0] == 5'd0) ? 6'd32 : {1'b0, bus.amount[4:0]};
                3'd4:       count_eff = 6'd1;
                default:    count_eff = '0;
            endcase
        end
    end

    assign k = (remaining > 6'(STEP)) ? 6'(STEP) : remaining;

    always_comb begin
        work_next  = work;
        carry_next = carry;
        for (int i = 0; i < STEP; i++) begin
            if (6'(i) < k) begin
                case (op_q)
                    3'd0: begin
                        carry_next = work_next[N-1];
                        work_next  = {work_next[N-2:0], 1'b0};
                    end
                    3'd1: begin
                        carry_next = work_next[0];
                        work_next  = {1'b0, work_next[N-1:1]};
                    end
                    3'd2: begin
                        carry_next = work_next[0];
                        work_next  = {work_next[N-1], work_next[N-1:1]};
                    end
                    3'd3: begin
                        carry_next = work_next[0];
                        work_next  = {work_next[0], work_next[N-1:1]};
                    end
                    3'd4: begin
                        carry_next = work_next[0];
                        work_next  = {fill_q, work_next[N-1:1]};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = (count_eff != 6'd0) ? SHIFT : DONE;
            SHIFT:   if (remaining <= 6'(STEP)) state_next = DONE;
            DONE:    if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.res_valid = (state == DONE);
        bus.busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            work      <= '0;
            carry     <= 1'b0;
            fill_q    <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    op_q      <= bus.op;
                    work      <= bus.value;
                    carry     <= bus.carry_in;
                    fill_q    <= bus.carry_in;
                    remaining <= count_eff;
                end
                SHIFT: begin
                    work      <= work_next;
                    carry     <= carry_next;
                    remaining <= remaining - k;
                end
                default: ;
            endcase
        end
    end

    assign bus.result    = work;
    assign bus.carry_out = carry;
endmodule
